// File: rtl/scalar_pkg.sv
// Shared constants and types for the scalar writeback path.
package scalar_pkg;

  localparam int REG_W      = 36;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  // One candidate register-file write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_W-1:0]      data;
  } wb_req_t;

endpackage

// File: rtl/scalar_writeback_arbiter_if.sv
// Bundle of result-source, issue and register-file signals around the writeback arbiter.
interface scalar_writeback_arbiter_if
  import scalar_pkg::*;
#(
  parameter int NUM_SRC = 3
);

  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr;
  logic [NUM_SRC*REG_W-1:0]      src_data;
  logic [NUM_SRC-1:0]            src_ready;
  logic                          issue_valid;
  logic [REG_ADDR_W-1:0]         issue_addr;
  logic [NUM_REGS-1:0]           pend;
  logic                          rf_we;
  logic [REG_ADDR_W-1:0]         rf_addr;
  logic [REG_W-1:0]              rf_data;
  logic                          wb_err;

  // Sources, issue logic and the register file sit on the master side.
  modport master (
    output src_valid, src_addr, src_data, issue_valid, issue_addr,
    input  src_ready, pend, rf_we, rf_addr, rf_data, wb_err
  );

  // The writeback arbiter itself.
  modport slave (
    input  src_valid, src_addr, src_data, issue_valid, issue_addr,
    output src_ready, pend, rf_we, rf_addr, rf_data, wb_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic found;

  // Two passes: requesters at or above ptr first, then the wrapped-around ones below it.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (PTR_W'(i) >= ptr)) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (PTR_W'(i) < ptr)) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scalar_writeback_arbiter.sv
// Writeback stage: merges result sources onto the single register-file write port
// and keeps the per-register pending-write scoreboard used for hazard detection.
module scalar_writeback_arbiter
  import scalar_pkg::*;
#(
  parameter int NUM_SRC = 3
) (
  input logic                       clk,
  input logic                       rst,
  scalar_writeback_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      g_idx;
  logic [NUM_SRC-1:0]    gnt;
  logic [NUM_SRC-1:0]    ready;
  logic                  grant;
  wb_req_t               g_req;
  logic [NUM_REGS-1:0]   set_mask;
  logic [NUM_REGS-1:0]   clr_mask;
  logic [NUM_REGS-1:0]   pend_q;
  logic                  dbl_issue;
  logic                  bad_wb;
  logic                  we_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [REG_W-1:0]      data_q;
  logic                  err_q;

  // Arbitration looks only at valid bits and the pointer, never at result data.
  rr_arbiter #(
    .N     (NUM_SRC),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (bus.src_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  // Grants are suppressed during reset so nothing is accepted that would be discarded.
  always_comb begin
    ready = rst ? '0 : gnt;
  end

  // Select the granted source's destination and data.
  always_comb begin
    grant = 1'b0;
    g_idx = '0;
    g_req = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ready[i]) begin
        grant      = 1'b1;
        g_idx      = PTR_W'(i);
        g_req.addr = bus.src_addr[REG_ADDR_W*i +: REG_ADDR_W];
        g_req.data = bus.src_data[REG_W*i +: REG_W];
      end
    end
  end

  // Scoreboard set/clear masks and the two protocol-error conditions.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.issue_valid) set_mask[bus.issue_addr] = 1'b1;
    if (grant)           clr_mask[g_req.addr]     = 1'b1;
    dbl_issue = bus.issue_valid && pend_q[bus.issue_addr] && !clr_mask[bus.issue_addr];
    bad_wb    = grant && !pend_q[g_req.addr];
  end

  // Pointer, registered write port, scoreboard (set beats clear) and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      we_q   <= grant;
      pend_q <= (pend_q & ~clr_mask) | set_mask;
      if (grant) begin
        rr_ptr <= (g_idx == PTR_W'(NUM_SRC - 1)) ? '0 : g_idx + 1'b1;
        addr_q <= g_req.addr;
        data_q <= g_req.data;
      end
      if (dbl_issue || bad_wb) err_q <= 1'b1;
    end
  end

  assign bus.src_ready = ready;
  assign bus.pend      = pend_q;
  assign bus.rf_we     = we_q;
  assign bus.rf_addr   = addr_q;
  assign bus.rf_data   = data_q;
  assign bus.wb_err    = err_q;

endmodule

// File: doc/scalar_writeback_arbiter.md
# scalar_writeback_arbiter

Writeback stage directly upstream of the scalar register file. Merges result streams from several execution sources (ALU, load unit, multi-cycle unit) onto the file's single write port, one write per cycle. Maintains the per-register pending scoreboard that issue logic uses to detect RAW/WAW hazards. The output write is registered, so the register file sees a clean `we`/`write_addr`/`write_data` one cycle after a result is accepted.

## Interface
- `NUM_SRC`, default 3: number of result sources; index 0 is the first candidate after reset.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `src_valid`  in  NUM_SRC: source i has a result.
- `src_addr`  in  NUM_SRC*5: destination register of source i, at bits [5i+4:5i].
- `src_data`  in  NUM_SRC*36: result of source i, at bits [36i+35:36i].
- `src_ready`  out  NUM_SRC: one-hot grant, combinational; a transfer occurs when `src_valid[i] & src_ready[i]`.
- `issue_valid`  in  1: an instruction writing `issue_addr` was issued this cycle.
- `issue_addr`  in  5: destination register of the issued instruction.
- `pend`  out  32: pending-write bitmap; bit r is set while a write to r is outstanding.
- `rf_we`  out  1: register-file write enable.
- `rf_addr`  out  5: register-file write address.
- `rf_data`  out  36: register-file write data.
- `wb_err`  out  1: sticky protocol-error flag.

## Operation
- **Arbitration**
  - Round-robin over valid sources, starting at pointer `rr_ptr`.
  - At most one `src_ready` bit is high per cycle, and only on a valid source.
  - `src_ready` is 0 for every source when no source is valid.
  - After a grant to source g, `rr_ptr` becomes (g+1) mod NUM_SRC. Without a grant, the pointer holds.
  - `src_ready` must never depend on the `src_data` contents.
- **Output register**
  - On a grant: next cycle `rf_we`=1, `rf_addr`=granted addr, `rf_data`=granted data.
  - Without a grant: `rf_we`=0, and `rf_addr`/`rf_data` hold their last value.
- **Scoreboard** (per register r, evaluated each edge)
  - Set: `issue_valid & issue_addr==r`.
  - Clear: a grant this cycle with granted addr==r.
  - Set and clear in the same cycle: set wins. The new instruction is outstanding.
  - The clear takes effect on the same edge that loads `rf_we`=1, so `pend[r]` falls in the cycle the write is presented.
- **Errors** (`wb_err` sets and stays set until `rst`)
  - `issue_valid` to an address whose `pend` bit is already 1 and is not being cleared this cycle (double-issue).
  - A grant to an address whose `pend` bit is 0 (unexpected writeback).
  - On either error the block still performs the write and the scoreboard update normally.
- All 32 registers are treated identically; r0 is not special-cased.

## Timing
- Reset values: `rf_we`=0, `rf_addr`=0, `rf_data`=0, `pend`=0, `wb_err`=0, `rr_ptr`=0. `src_ready` is 0 while `rst` is high.
- Latency: accept at edge N, then `rf_we` is high during cycle N+1.
- Throughput: one write per cycle when any source is valid.
- Fairness: a continuously valid source is granted within NUM_SRC cycles.
- Handshake rule for sources: hold `src_valid`/`src_addr`/`src_data` stable until `src_ready` is seen.
- Reset mid-operation: any accepted-but-unwritten result is discarded, and sources must re-present after reset.
- `pend` is a registered output; an issue at edge N is visible from cycle N+1.

## Structure
- `scalar_pkg`
  - Constants: `REG_W`=36, `NUM_REGS`=32, `REG_ADDR_W`=5.
  - Typedef `wb_req_t {logic [4:0] addr; logic [35:0] data;}`.
- Sub-module `rr_arbiter`, parameterized by N
  - Inputs: `req`, `ptr`. Output: one-hot `gnt`.
  - Purely combinational; the pointer register lives in the parent.

## Test plan
- Reset, then single source: issue r5; src1 valid addr 5 data 36'h123456789. Expect `src_ready`=3'b010; next cycle `rf_we`=1, `rf_addr`=5, `rf_data`=36'h123456789, `pend[5]`=0, `wb_err`=0.
- All three sources valid continuously with distinct pending addrs 1/2/3. Expect grants in order 0,1,2,0,…, `rf_we` high every cycle, and no source starved.
- Issue r7 and grant a write to r7 in the same cycle, with r7 previously pending. Expect `pend[7]`=1 afterward and `wb_err`=0.
- Issue r9 twice without an intervening writeback → `wb_err`=1 and it stays 1. Writeback to non-pending r12 → `wb_err`=1, and the write is still performed.
- Assert `rst` with a result granted in the previous cycle. Expect `rf_we`=0, `pend`=0, `rr_ptr`=0 next cycle; then src2 alone valid is granted immediately.
- No valid sources for 10 cycles. Expect `rf_we`=0 throughout, `rf_addr`/`rf_data` unchanged, `rr_ptr` unchanged.
